// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator: extends the instruction immediate to XLEN
// and passes it, with a sideband tag, through a 2-entry valid/ready skid buffer.
module imm_extend_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] SRC_I   = 3'b000;
  localparam logic [2:0] SRC_S   = 3'b001;
  localparam logic [2:0] SRC_B   = 3'b010;
  localparam logic [2:0] SRC_J   = 3'b011;
  localparam logic [2:0] SRC_U   = 3'b100;
  localparam logic [2:0] SRC_SH  = 3'b101;
  localparam logic [2:0] SRC_CSR = 3'b110;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ill_q, out_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_ill_q, skid_ill_d;

  logic [XLEN-1:0]  imm_c;
  logic             ill_c;
  logic             in_xfer;
  logic             out_xfer;

  // The opcode field never contributes to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // Immediate decode; signed casts sign-extend from instr[31].
  always_comb begin
    imm_c = '0;
    ill_c = 1'b0;
    unique case (in_imm_src)
      SRC_I:   imm_c = XLEN'($signed(in_instr[31:20]));
      SRC_S:   imm_c = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      SRC_B:   imm_c = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
      SRC_J:   imm_c = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
      SRC_U:   imm_c = XLEN'($signed({in_instr[31:12], 12'b0}));
      SRC_SH: begin
        if (IS_RV64) begin
          imm_c = XLEN'(in_instr[25:20]);
        end else begin
          imm_c = XLEN'(in_instr[24:20]);
          ill_c = in_instr[25];
        end
      end
      SRC_CSR: imm_c = XLEN'(in_instr[31:20]);
      default: begin
        imm_c = '0;
        ill_c = 1'b1;
      end
    endcase
  end

  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

  // Output/skid next state; flush only clears valids, data is retained.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_xfer) begin
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_imm_d   = imm_c;
        out_tag_d   = in_tag;
        out_ill_d   = ill_c;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = imm_c;
        skid_tag_d   = in_tag;
        skid_ill_d   = ill_c;
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

endmodule
